// File: rtl/mem_burst_pkg.sv
// Shared types and constants for the 4x64-bit burst memory responder.
// Beat width, beats per line and the responder FSM state encoding.
package mem_burst_pkg;

  localparam int BURST_W = 64;
  localparam int BEATS   = 4;
  localparam int LINE_W  = BURST_W * BEATS;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BURST,
    GAP
  } burst_state_t;

  typedef logic [BURST_W-1:0] beat_t;

endpackage

// File: rtl/burst_mem_array.sv
// Beat-granular backing store: one synchronous write port, one async read.
// Contents are never reset so they survive a responder reset.
module burst_mem_array
  import mem_burst_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  beat_t         wdata,
  input  logic [AW-1:0] raddr,
  output beat_t         rdata
);

  beat_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/burst_mem_responder.sv
// Memory-side responder for 4-beat line bursts with programmable latency.
// FSM IDLE -> WAIT -> BURST -> GAP; resp and read beats are registered.
module burst_mem_responder
  import mem_burst_pkg::*;
#(
  parameter int DEPTH_LINES = 64,
  parameter int LATENCY     = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [31:0] mem_addr_i,
  input  beat_t       mem_burst_i,
  output beat_t       mem_burst_o,
  output logic        mem_resp_o
);

  localparam int LW = $clog2(DEPTH_LINES);
  localparam int BW = $clog2(BEATS);

  burst_state_t   state;
  logic           is_read;
  logic [LW-1:0]  line;
  logic [3:0]     lat_cnt;
  logic [BW-1:0]  beat;
  logic [BW-1:0]  rd_beat;
  beat_t          rd_data;
  logic           req;
  logic           last;
  logic           we;
  logic           addr_unused;

  assign req  = mem_read_i | mem_write_i;
  assign last = (beat == BW'(BEATS - 1));
  assign we   = (state == BURST) && !is_read;

  // Look one beat ahead so the read data registers together with resp.
  assign rd_beat = (state == BURST) ? beat + BW'(1) : '0;

  assign addr_unused = ^{mem_addr_i[31:5+LW], mem_addr_i[4:0]};

  burst_mem_array #(
    .DEPTH (DEPTH_LINES * BEATS),
    .AW    (LW + BW)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .waddr ({line, beat}),
    .wdata (mem_burst_i),
    .raddr ({line, rd_beat}),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      is_read     <= 1'b0;
      line        <= '0;
      lat_cnt     <= '0;
      beat        <= '0;
      mem_resp_o  <= 1'b0;
      mem_burst_o <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            is_read <= mem_read_i;
            line    <= mem_addr_i[5 +: LW];
            lat_cnt <= 4'(LATENCY - 1);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (!req) begin
            state <= IDLE;
          end else if (lat_cnt == 4'd0) begin
            state       <= BURST;
            beat        <= '0;
            mem_resp_o  <= 1'b1;
            mem_burst_o <= is_read ? rd_data : '0;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        BURST: begin
          if (last || !req) begin
            state       <= GAP;
            beat        <= '0;
            mem_resp_o  <= 1'b0;
            mem_burst_o <= '0;
          end else begin
            beat        <= beat + BW'(1);
            mem_resp_o  <= 1'b1;
            mem_burst_o <= is_read ? rd_data : '0;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
